ysyx_23060332_ifu: RTL and testbench

Instruction fetch unit for the ysyx_23060332 core. It owns the PC and issues one fetch request per instruction over a valid/ready instruction-memory interface. It presents the fetched word and its address to the decode stage, and advances the PC on a retire pulse from the core, either sequentially or to a redirect target from the EXU. The core is non-pipelined, so at most one instruction is in flight.

---
 rtl/ysyx_23060332_ifu_pkg.sv | 25 ++
 rtl/ysyx_23060332_pc_reg.sv | 40 ++++
 rtl/ysyx_23060332_ifu.sv | 123 ++++++++++++
 tb/tb_ysyx_23060332_ifu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060332_ifu_pkg.sv
// ============================================================================
// ysyx_23060332_ifu_pkg : shared constants for the instruction fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package ysyx_23060332_ifu_pkg;

    localparam logic [2:0] IFU_S_IDLE  = 3'd0;
    localparam logic [2:0] IFU_S_REQ   = 3'd1;
    localparam logic [2:0] IFU_S_WAIT  = 3'd2;
    localparam logic [2:0] IFU_S_VALID = 3'd3;
    localparam logic [2:0] IFU_S_ERR   = 3'd4;

    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    // A word fetch needs bit 1 clear; bit 0 is always forced low by the PC mux.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_23060332_pc_reg.sv
// ============================================================================
// ysyx_23060332_pc_reg : PC register with load enable and next-PC mux
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_23060332_pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic              unused_jump_bit0;

    assign unused_jump_bit0 = jump_addr_i[0];

    // Redirect targets drop bit 0 (JALR rule); pc+4 wraps naturally.
    assign next_pc_o = jump_en_i ? {jump_addr_i[ADDR_W-1:1], 1'b0}
                                 : pc_q + ADDR_W'(4);
    assign pc_o      = pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= next_pc_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_23060332_ifu.sv
// ============================================================================
// ysyx_23060332_ifu : single-outstanding instruction fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

module ysyx_23060332_ifu
    import ysyx_23060332_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              wb_done,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    output logic              fetch_err
);

    localparam logic [INST_W-1:0] NOP = INST_W'(INST_NOP);

    logic [2:0]        state_q,      state_d;
    logic [INST_W-1:0] inst_q,       inst_d;
    logic [ADDR_W-1:0] inst_addr_q,  inst_addr_d;
    logic              inst_valid_q, inst_valid_d;
    logic              fetch_err_q,  fetch_err_d;

    logic              retire;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] next_pc;

    assign retire = (state_q == IFU_S_VALID) && wb_done;

    ysyx_23060332_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (retire),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
        .pc_o        (pc),
        .next_pc_o   (next_pc)
    );

    always_comb begin
        state_d      = state_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        inst_valid_d = inst_valid_q;
        fetch_err_d  = fetch_err_q;
        case (state_q)
            IFU_S_IDLE:  state_d = IFU_S_REQ;
            IFU_S_REQ:   if (imem_req_ready) state_d = IFU_S_WAIT;
            IFU_S_WAIT: begin
                if (imem_rsp_valid && !imem_rsp_err) begin
                    inst_d       = imem_rsp_data;
                    inst_addr_d  = pc;
                    inst_valid_d = 1'b1;
                    state_d      = IFU_S_VALID;
                end else if (imem_rsp_valid) begin
                    fetch_err_d  = 1'b1;
                    inst_valid_d = 1'b0;
                    inst_d       = NOP;
                    state_d      = IFU_S_ERR;
                end
            end
            IFU_S_VALID: begin
                if (wb_done) begin
                    inst_valid_d = 1'b0;
                    inst_d       = NOP;
                    // The PC still takes a misaligned target so a debugger can see it.
                    if (is_misaligned(32'(next_pc))) begin
                        fetch_err_d = 1'b1;
                        state_d     = IFU_S_ERR;
                    end else begin
                        state_d     = IFU_S_REQ;
                    end
                end
            end
            IFU_S_ERR:   state_d = IFU_S_ERR;
            default:     state_d = IFU_S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IFU_S_IDLE;
            inst_q       <= NOP;
            inst_addr_q  <= ADDR_W'(RESET_PC);
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign imem_req_valid = (state_q == IFU_S_REQ);
    assign imem_req_addr  = pc;
    assign inst_o         = inst_q;
    assign inst_addr_o    = inst_addr_q;
    assign inst_valid_o   = inst_valid_q;
    assign fetch_err      = fetch_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060332_ifu.sv
// ============================================================================
// tb_ysyx_23060332_ifu : directed self-checking bench for the fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_23060332_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en = 1'b0;
    logic [31:0] jump_addr = '0;
    logic        wb_done = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        fetch_err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ysyx_23060332_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .jump_en        (jump_en),
        .jump_addr      (jump_addr),
        .wb_done        (wb_done),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_o         (inst_o),
        .inst_addr_o    (inst_addr_o),
        .inst_valid_o   (inst_valid_o),
        .fetch_err      (fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one fetch: optional stall (with a stray response pulse), handshake, response.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data,
                            input logic err, input int stall);
        int   n = 0;
        exp_t e;
        while (!imem_req_valid && n < 10) begin
            step();
            n++;
        end
        check("req_valid_seen", 32'(imem_req_valid), 32'd1);
        check("req_addr", imem_req_addr, exp_addr);
        for (int i = 0; i < stall; i++) begin
            if (i == 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            step();
            imem_rsp_valid = 1'b0;
            check("stall_req_valid", 32'(imem_req_valid), 32'd1);
            check("stall_req_addr", imem_req_addr, exp_addr);
            check("stall_inst_valid", 32'(inst_valid_o), 32'd0);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("req_drop_after_hs", 32'(imem_req_valid), 32'd0);
        check("wait_inst_valid", 32'(inst_valid_o), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        if (!err) sb_q.push_back('{addr: exp_addr, data: data});
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (!err) begin
            check("inst_valid", 32'(inst_valid_o), 32'd1);
            check("sb_nonempty", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("inst_o", inst_o, e.data);
                check("inst_addr_o", inst_addr_o, e.addr);
            end
        end else begin
            check("buserr_fetch_err", 32'(fetch_err), 32'd1);
            check("buserr_inst_valid", 32'(inst_valid_o), 32'd0);
            check("buserr_inst_nop", inst_o, NOP);
            check("buserr_req_valid", 32'(imem_req_valid), 32'd0);
        end
    endtask

    task automatic retire(input logic jmp, input logic [31:0] target,
                          input logic [31:0] exp_pc, input logic exp_err);
        wb_done   = 1'b1;
        jump_en   = jmp;
        jump_addr = target;
        step();
        wb_done   = 1'b0;
        jump_en   = 1'b0;
        check("retire_pc", imem_req_addr, exp_pc);
        check("retire_inst_valid", 32'(inst_valid_o), 32'd0);
        check("retire_inst_nop", inst_o, NOP);
        check("retire_fetch_err", 32'(fetch_err), 32'(exp_err));
        check("retire_req_valid", 32'(imem_req_valid), 32'(!exp_err));
    endtask

    task automatic check_reset_state();
        check("rst_pc", imem_req_addr, 32'h8000_0000);
        check("rst_inst", inst_o, NOP);
        check("rst_inst_addr", inst_addr_o, 32'h8000_0000);
        check("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
    endtask

    initial begin
        exp_t e;
        // Reset state and exact first-fetch latency.
        step();
        step();
        check_reset_state();
        rst = 1'b0;
        imem_req_ready = 1'b1;
        step();
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, 32'h8000_0000);
        step();
        imem_req_ready = 1'b0;
        check("first_wait_valid", 32'(inst_valid_o), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        sb_q.push_back('{addr: 32'h8000_0000, data: 32'h0010_0093});
        step();
        imem_rsp_valid = 1'b0;
        check("first_inst_valid", 32'(inst_valid_o), 32'd1);
        e = sb_q.pop_front();
        check("first_inst", inst_o, e.data);
        check("first_inst_addr", inst_addr_o, e.addr);

        // Sequential advance, then backpressure with a stray response.
        retire(1'b0, 32'h0, 32'h8000_0004, 1'b0);
        do_fetch(32'h8000_0004, 32'h0020_8113, 1'b0, 5);

        // Redirect with bit 0 cleared.
        retire(1'b1, 32'h8000_0101, 32'h8000_0100, 1'b0);
        do_fetch(32'h8000_0100, 32'h0000_006F, 1'b0, 0);

        // Misaligned redirect: sticky error, no more requests.
        retire(1'b1, 32'h8000_0102, 32'h8000_0102, 1'b1);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("err_no_req", 32'(imem_req_valid), 32'd0);
            check("err_sticky", 32'(fetch_err), 32'd1);
        end
        imem_req_ready = 1'b0;

        // Synchronous-aligned reset pulse restores everything.
        rst = 1'b1;
        step();
        check_reset_state();
        rst = 1'b0;

        // Bus error, then wb_done pulses must have no effect.
        do_fetch(32'h8000_0000, 32'h1234_5678, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            wb_done   = 1'b1;
            jump_en   = 1'b1;
            jump_addr = 32'h8000_0200;
            step();
            check("err_wb_pc", imem_req_addr, 32'h8000_0000);
            check("err_wb_valid", 32'(inst_valid_o), 32'd0);
            check("err_wb_req", 32'(imem_req_valid), 32'd0);
        end
        wb_done = 1'b0;
        jump_en = 1'b0;

        // Asynchronous reset asserted away from a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_reset_state();
        step();
        rst = 1'b0;

        // PC wrap at the top of the address space.
        do_fetch(32'h8000_0000, 32'h0000_0513, 1'b0, 0);
        retire(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0);
        do_fetch(32'hFFFF_FFFC, 32'h0040_0593, 1'b0, 2);
        retire(1'b0, 32'h0, 32'h0000_0000, 1'b0);
        do_fetch(32'h0000_0000, 32'h0050_0613, 1'b0, 0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
